// File: rtl/gravity_player_ctrl.sv
// Gravity-flip player motion controller: tracks the player's y across platform lanes,
// falls toward the gravity side, snaps onto crossed platforms and flags death off-field.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_RESTING | standing on lane `lane`, waiting for platform loss or gravity flip
// ST_FALLING | moving STEP pixels per tick_en toward the gravity side
// ST_DEAD    | left the playfield or killed; everything frozen until rst_n
module gravity_player_ctrl #(
    parameter int NUM_LANES  = 3,
    parameter int HEIGHT_W   = 9,
    parameter int BASE_Y     = 40,
    parameter int LANE_PITCH = 130,
    parameter int STEP       = 2,
    parameter int MAX_Y      = 400,
    parameter int START_LANE = 1,
    parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_en,
    input  logic                 grav_dir,
    input  logic                 kill,
    input  logic [NUM_LANES-1:0] lines,
    output logic [HEIGHT_W-1:0]  height,
    output logic [LANE_W-1:0]    lane,
    output logic                 falling,
    output logic                 landed,
    output logic                 dead
);

    localparam logic [1:0] ST_RESTING = 2'd0;
    localparam logic [1:0] ST_FALLING = 2'd1;
    localparam logic [1:0] ST_DEAD    = 2'd2;

    // Two guard bits: one for sign below zero, one so MAX_Y + STEP cannot wrap.
    localparam int SW = HEIGHT_W + 2;
    localparam logic signed [SW-1:0]   STEP_S     = SW'(STEP);
    localparam logic signed [SW-1:0]   MAX_S      = SW'(MAX_Y);
    localparam logic [HEIGHT_W-1:0]    MAX_H      = HEIGHT_W'(MAX_Y);
    localparam logic [HEIGHT_W-1:0]    START_Y    = HEIGHT_W'(BASE_Y + START_LANE * LANE_PITCH);
    localparam logic [LANE_W-1:0]      START_LANE_L = LANE_W'(START_LANE);

    logic [1:0]               state;
    logic                     grav_q;
    logic signed [SW-1:0]     lane_y [NUM_LANES];
    logic signed [SW-1:0]     h_cur;
    logic signed [SW-1:0]     h_next;
    logic                     hit;
    logic [LANE_W-1:0]        hit_lane;
    logic signed [SW-1:0]     hit_y;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane_y
            assign lane_y[g] = SW'(BASE_Y + g * LANE_PITCH);
        end
    endgenerate

    // Candidate search: only lanes strictly beyond the current height, up to h_next.
    always_comb begin
        h_cur    = $signed({2'b00, height});
        h_next   = grav_dir ? (h_cur + STEP_S) : (h_cur - STEP_S);
        hit      = 1'b0;
        hit_lane = '0;
        hit_y    = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (lines[j]) begin
                if (!grav_dir && (lane_y[j] >= h_next) && (lane_y[j] < h_cur)
                    && (!hit || (lane_y[j] > hit_y))) begin
                    hit      = 1'b1;
                    hit_lane = LANE_W'(j);
                    hit_y    = lane_y[j];
                end else if (grav_dir && (lane_y[j] > h_cur) && (lane_y[j] <= h_next)
                    && (!hit || (lane_y[j] < hit_y))) begin
                    hit      = 1'b1;
                    hit_lane = LANE_W'(j);
                    hit_y    = lane_y[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RESTING;
            height <= START_Y;
            lane   <= START_LANE_L;
            grav_q <= 1'b0;
            landed <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (kill) begin
                state <= ST_DEAD;
            end else begin
                case (state)
                    ST_RESTING: begin
                        if (!lines[lane] || (grav_dir != grav_q))
                            state <= ST_FALLING;
                    end
                    ST_FALLING: begin
                        if (tick_en) begin
                            if (hit) begin
                                height <= hit_y[HEIGHT_W-1:0];
                                lane   <= hit_lane;
                                state  <= ST_RESTING;
                                landed <= 1'b1;
                                grav_q <= grav_dir;
                            end else if (!grav_dir && (h_next[SW-1] || (h_next == '0))) begin
                                height <= '0;
                                state  <= ST_DEAD;
                            end else if (grav_dir && (h_next >= MAX_S)) begin
                                height <= MAX_H;
                                state  <= ST_DEAD;
                            end else begin
                                height <= h_next[HEIGHT_W-1:0];
                            end
                        end
                    end
                    default: state <= ST_DEAD;
                endcase
            end
        end
    end

    assign falling = (state == ST_FALLING);
    assign dead    = (state == ST_DEAD);

endmodule
